// File: rtl/alu_sched.sv
// Round-robin scheduler that shares one fixed-latency ALU among NREQ requesters.
// One operation is in flight at a time: grant in IDLE, wait ALU_LAT cycles,
// then hold the captured result until the consumer takes it.
module alu_sched #(
    parameter int unsigned N       = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_inp1,
    input  logic [NREQ*N-1:0]        req_inp2,
    input  logic [NREQ*2-1:0]        req_op,
    output logic [N-1:0]             alu_inp1,
    output logic [N-1:0]             alu_inp2,
    output logic [1:0]               alu_op_code,
    input  logic [2*N-1:0]           alu_outp,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*N-1:0]           rsp_data
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned LW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      id_q;
    logic [LW-1:0]       lat_cnt_q;
    logic [N-1:0]        alu_inp1_q, alu_inp2_q;
    logic [1:0]          alu_op_q;
    logic                rsp_valid_q;
    logic [2*N-1:0]      rsp_data_q;

    logic                grant_found;
    logic [IDW-1:0]      grant_id;
    logic [N-1:0]        win_inp1, win_inp2;
    logic [1:0]          win_op;
    logic                handshake;
    logic [IDW-1:0]      next_ptr;

    // Round-robin search: walk offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        logic [IDW:0] sum;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(NREQ)) begin
                sum = sum - (IDW + 1)'(NREQ);
            end
            if (req_valid[sum[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = sum[IDW-1:0];
            end
        end
    end

    // Select the winning requester's operands and op code.
    always_comb begin
        win_inp1 = '0;
        win_inp2 = '0;
        win_op   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                win_inp1 = req_inp1[k*N +: N];
                win_inp2 = req_inp2[k*N +: N];
                win_op   = req_op[k*2 +: 2];
            end
        end
    end

    assign handshake = (state_q == StIdle) && grant_found;
    assign next_ptr  = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_found) state_d = StWait;
            StWait:  if (lat_cnt_q == '0) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: one-hot accept only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (!reset && handshake) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Datapath: operand launch, latency countdown, result capture and pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            lat_cnt_q   <= '0;
            alu_inp1_q  <= '0;
            alu_inp2_q  <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (handshake) begin
                alu_inp1_q <= win_inp1;
                alu_inp2_q <= win_inp2;
                alu_op_q   <= win_op;
                id_q       <= grant_id;
                lat_cnt_q  <= LW'(ALU_LAT - 1);
            end
            if (state_q == StWait) begin
                if (lat_cnt_q == '0) begin
                    rsp_data_q  <= alu_outp;
                    rsp_valid_q <= 1'b1;
                end else begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                end
            end
            // Pointer moves only when the consumer takes the response.
            if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rr_ptr_q    <= next_ptr;
            end
        end
    end

    assign alu_inp1    = alu_inp1_q;
    assign alu_inp2    = alu_inp2_q;
    assign alu_op_code = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a combinational stub ALU (ALU_LAT = 1).
module tb_alu_sched;

    localparam int N = 8;
    localparam int NREQ = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_inp1;
    logic [NREQ*N-1:0] req_inp2;
    logic [NREQ*2-1:0] req_op;
    logic [N-1:0]      alu_inp1;
    logic [N-1:0]      alu_inp2;
    logic [1:0]        alu_op_code;
    logic [2*N-1:0]    alu_outp;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*N-1:0]    rsp_data;

    int total = 0;
    int bad = 0;

    alu_sched #(.N(N), .NREQ(NREQ), .ALU_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_inp1    (req_inp1),
        .req_inp2    (req_inp2),
        .req_op      (req_op),
        .alu_inp1    (alu_inp1),
        .alu_inp2    (alu_inp2),
        .alu_op_code (alu_op_code),
        .alu_outp    (alu_outp),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data)
    );

    // Stub ALU: 00 multiply, 01 add, 10 concatenate, 11 xor.
    always_comb begin
        case (alu_op_code)
            2'b00:   alu_outp = {8'h00, alu_inp1} * {8'h00, alu_inp2};
            2'b01:   alu_outp = {8'h00, alu_inp1} + {8'h00, alu_inp2};
            2'b10:   alu_outp = {alu_inp1, alu_inp2};
            default: alu_outp = {8'h00, alu_inp1 ^ alu_inp2};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endfunction

    function automatic int onehot_id(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        #1;
    endtask

    // One full operation: grant in cycle 0, operands in cycle 1, response in cycle 2.
    task automatic run_op(input logic [3:0] vmask, input int gid, input logic [7:0] a,
                          input logic [7:0] b, input logic [1:0] op, input logic [15:0] exp);
        req_inp1[gid*8 +: 8] = a;
        req_inp2[gid*8 +: 8] = b;
        req_op[gid*2 +: 2] = op;
        req_valid = vmask;
        #1;
        chk("grant", 32'(req_ready), 32'(4'b0001 << gid));
        chk("no_rsp_c0", 32'(rsp_valid), 32'd0);
        step();
        req_valid = '0;
        #1;
        chk("alu_inp1", 32'(alu_inp1), 32'(a));
        chk("alu_inp2", 32'(alu_inp2), 32'(b));
        chk("alu_op", 32'(alu_op_code), 32'(op));
        chk("ready_wait", 32'(req_ready), 32'd0);
        chk("no_rsp_c1", 32'(rsp_valid), 32'd0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(gid));
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        chk("ready_resp", 32'(req_ready), 32'd0);
        step();
    endtask

    initial begin
        int gids[5];
        int gcyc[5];
        int n;
        int g;
        logic [15:0] held_data;

        vecs[0] = '{id: 2, a: 8'h0A, b: 8'h14, op: 2'b01, exp: 16'h001E};
        vecs[1] = '{id: 0, a: 8'hFF, b: 8'hFF, op: 2'b00, exp: 16'hFE01};
        vecs[2] = '{id: 1, a: 8'hFF, b: 8'h01, op: 2'b01, exp: 16'h0100};
        vecs[3] = '{id: 3, a: 8'h12, b: 8'h34, op: 2'b10, exp: 16'h1234};
        vecs[4] = '{id: 2, a: 8'hF0, b: 8'h3C, op: 2'b11, exp: 16'h00CC};
        vecs[5] = '{id: 1, a: 8'h0C, b: 8'h0D, op: 2'b00, exp: 16'h009C};

        reset = 1'b1;
        req_valid = 4'hF;
        req_inp1 = 32'hDEADBEEF;
        req_inp2 = 32'hCAFEF00D;
        req_op = 8'hE4;
        rsp_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_inp1", 32'(alu_inp1), 32'd0);
        chk("rst_inp2", 32'(alu_inp2), 32'd0);
        chk("rst_op", 32'(alu_op_code), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        reset = 1'b0;
        #1;
        chk("first_grant_low", 32'(req_ready), 32'd1);
        req_valid = '0;
        #1;

        // Single-requester table.
        for (int i = 0; i < 6; i++) begin
            run_op(4'(1 << vecs[i].id), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].exp);
        end

        // All four valid: order 0,1,2,3,0 spaced three cycles apart.
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_inp1[i*8 +: 8] = 8'(i + 1);
            req_inp2[i*8 +: 8] = 8'h10;
            req_op[i*2 +: 2] = 2'b01;
        end
        for (int i = 0; i < 5; i++) begin
            gids[i] = -1;
            gcyc[i] = -100;
        end
        n = 0;
        req_valid = 4'hF;
        #1;
        for (int c = 0; c < 13; c++) begin
            if (req_ready != '0 && n < 5) begin
                gids[n] = onehot_id(req_ready);
                gcyc[n] = c;
                n++;
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        chk("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(gids[i]), 32'(i % 4));
            if (i > 0) chk("rr_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end

        // Consumer stalls five cycles; pointer sits at 1.
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        g = 0;
        while (req_ready == '0 && g < 8) begin
            step();
            g++;
        end
        chk("stall_grant", 32'(req_ready), 32'b0010);
        step();
        step();
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_id", 32'(rsp_id), 32'd1);
        chk("stall_rsp_data", 32'(rsp_data), 32'h0012);
        held_data = rsp_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'h0012);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("exit_ready", 32'(req_ready), 32'd0);
        step();
        chk("post_release_grant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        #1;

        // Reset in WAIT discards the operation; next grant goes to lowest valid.
        req_inp1[16 +: 8] = 8'h33;
        req_inp2[16 +: 8] = 8'h44;
        req_op[4 +: 2] = 2'b10;
        req_valid = 4'b0100;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'b0100);
        step();
        chk("pre_rst_inp1", 32'(alu_inp1), 32'h33);
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_inp1", 32'(alu_inp1), 32'd0);
        chk("mid_rst_inp2", 32'(alu_inp2), 32'd0);
        chk("mid_rst_op", 32'(alu_op_code), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        step();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        run_op(4'b1010, 1, 8'h07, 8'h06, 2'b00, 16'h002A);

        // Serve 3, then 1001 must wrap to 0.
        run_op(4'b1000, 3, 8'h09, 8'h09, 2'b00, 16'h0051);
        run_op(4'b1001, 0, 8'h80, 8'h80, 2'b01, 16'h0100);

        // Requester 1 drops while 0 is served, then returns with fresh operands.
        apply_reset();
        req_inp1[8 +: 8] = 8'h55;
        req_inp2[8 +: 8] = 8'hAA;
        req_op[2 +: 2] = 2'b11;
        run_op(4'b0011, 0, 8'h02, 8'h03, 2'b00, 16'h0006);
        run_op(4'b0010, 1, 8'h21, 8'h03, 2'b01, 16'h0024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
